// File: rtl/rr_arb16.sv
// rtl/rr_arb16.sv - 16-way round-robin arbiter driving a registered 16:1 mux select
// An owner keeps the mux until its request drops or MAX_HOLD cycles have elapsed.
module rr_arb16 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:15] req,
  output logic [0:3]  sel,
  output logic [0:15] grant,
  output logic        valid,
  output logic [0:3]  ptr
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_sel;
  logic [3:0]  w_sel_nxt;
  logic [3:0]  r_ptr;
  logic [3:0]  w_ptr_nxt;
  logic [0:15] r_grant;
  logic [0:15] w_grant_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic [7:0]  r_hold;
  logic [7:0]  w_hold_nxt;
  logic        w_release;
  logic [3:0]  w_base;
  logic [4:0]  w_pick;

  // Returns {found, index} of the first set bit scanning base, base+1, ... mod 16.
  function automatic logic [4:0] rr_pick(input logic [0:15] r, input logic [3:0] base);
    logic [3:0] idx;
    rr_pick = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      idx = base + 4'(i);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign w_release = (r_state == BUSY) && (!req[r_sel] || (r_hold == HOLD_LAST));
  // On release the search starts just past the departing owner, so it is picked only when alone.
  assign w_base    = (r_state == BUSY) ? (r_sel + 4'd1) : r_ptr;
  assign w_pick    = rr_pick(req, w_base);

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_valid_nxt = r_valid;
    w_hold_nxt  = r_hold;
    case (r_state)
      IDLE: begin
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
        if (w_pick[4]) begin
          w_state_nxt              = BUSY;
          w_sel_nxt                = w_pick[3:0];
          w_grant_nxt[w_pick[3:0]] = 1'b1;
          w_valid_nxt              = 1'b1;
          w_hold_nxt               = 8'd0;
        end
      end
      BUSY: begin
        if (w_release) begin
          w_ptr_nxt   = w_base;
          w_grant_nxt = '0;
          if (w_pick[4]) begin
            w_sel_nxt                = w_pick[3:0];
            w_grant_nxt[w_pick[3:0]] = 1'b1;
            w_valid_nxt              = 1'b1;
            w_hold_nxt               = 8'd0;
          end else begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
          end
        end else if (r_hold != 8'hFF) begin
          w_hold_nxt = r_hold + 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= 4'd0;
      r_ptr   <= 4'd0;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_hold  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_valid <= w_valid_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign sel   = r_sel;
  assign grant = r_grant;
  assign valid = r_valid;
  assign ptr   = r_ptr;

endmodule

// File: tb/tb_rr_arb16.sv
// tb/tb_rr_arb16.sv - scoreboard bench for rr_arb16
// Directed vectors push expected outputs; a negedge monitor pops, compares and checks invariants.
module tb_rr_arb16;

  localparam int MAX_HOLD = 8;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [0:15] req   = '0;
  logic [0:3]  sel;
  logic [0:15] grant;
  logic        valid;
  logic [0:3]  ptr;

  rr_arb16 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .sel  (sel),
    .grant(grant),
    .valid(valid),
    .ptr  (ptr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         cyc;
    logic       v;
    logic [3:0] s;
    logic [3:0] p;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  int    run_len = 0;
  logic  prev_valid = 1'b0;
  logic [3:0] prev_sel = 4'd0;
  logic  prev_others = 1'b0;
  int    wait_c [0:15];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t        e;
    string       nm;
    logic [0:15] eg;
    int          worst;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      eg = '0;
      if (e.v) eg[e.s] = 1'b1;
      checks++;
      if (e.cyc != cyc || valid !== e.v || sel !== e.s || ptr !== e.p || grant !== eg) begin
        failures++;
        $display("FAIL %s cyc=%0d got valid=%0b sel=%0d ptr=%0d grant=%b want valid=%0b sel=%0d ptr=%0d grant=%b at_cyc=%0d",
                 nm, cyc, valid, sel, ptr, grant, e.v, e.s, e.p, eg, e.cyc);
      end
    end

    checks++;
    if (!(grant == '0 || $onehot(grant)) || (valid != (grant != '0)) || (valid && !grant[sel])) begin
      failures++;
      $display("FAIL onehot_sel cyc=%0d got valid=%0b sel=%0d grant=%b want zero/one-hot grant matching sel",
               cyc, valid, sel, grant);
    end

    if (valid && prev_valid && (sel == prev_sel) && prev_others) run_len++;
    else run_len = valid ? 1 : 0;
    checks++;
    if (run_len > MAX_HOLD) begin
      failures++;
      $display("FAIL max_hold cyc=%0d got run=%0d owner=%0d want run<=%0d", cyc, run_len, sel, MAX_HOLD);
    end
    prev_valid  = valid;
    prev_sel    = sel;
    prev_others = |(req & ~grant);

    worst = 0;
    for (int i = 0; i < 16; i++) begin
      if (req[4'(i)] && !grant[4'(i)]) wait_c[i]++;
      else wait_c[i] = 0;
      if (wait_c[i] > worst) worst = wait_c[i];
    end
    checks++;
    if (worst > 16 * MAX_HOLD) begin
      failures++;
      $display("FAIL starvation cyc=%0d got wait=%0d want wait<=%0d", cyc, worst, 16 * MAX_HOLD);
    end
  end

  task automatic push(input int c, input logic v, input int s, input int p, input string nm);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    e.s   = 4'(s);
    e.p   = 4'(p);
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // Outputs after the coming edge must match (v, s, p).
  task automatic drive(input logic [0:15] r, input logic v, input int s, input int p, input string nm);
    req = r;
    push(cyc + 1, v, s, p, nm);
    @(posedge clk);
    #1;
  endtask

  // Reset lands mid-cycle and must clear outputs before the next edge.
  task automatic do_reset(input string nm);
    @(posedge clk);
    #2;
    reset = 1'b1;
    push(cyc, 1'b0, 0, 0, nm);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [0:15] r;
    for (int i = 0; i < 16; i++) wait_c[i] = 0;

    do_reset("reset_state");

    for (int k = 1; k <= 8; k++) drive(16'b0010000000000000, 1'b1, 2, 0, "a_hold2");
    drive(16'b0010000000000000, 1'b1, 2, 3, "a_regrant2");
    drive(16'h0000, 1'b0, 2, 3, "a_release_idle");
    drive(16'h0000, 1'b0, 2, 3, "a_idle_stays");

    do_reset("b_reset");
    drive(16'b1000010000000001, 1'b1, 0, 0, "b_grant0");
    drive(16'b1000010000000001, 1'b1, 0, 0, "b_hold0");
    drive(16'b0000010000000001, 1'b1, 5, 1, "b_grant5");
    drive(16'b0000010000000001, 1'b1, 5, 1, "b_hold5");
    drive(16'b0000000000000001, 1'b1, 15, 6, "b_grant15");
    drive(16'b0000000000000001, 1'b1, 15, 6, "b_hold15");
    drive(16'h0000, 1'b0, 15, 0, "b_ptr_wrap");

    drive(16'b0000000000000100, 1'b1, 13, 0, "c_pre13");
    drive(16'h0000, 1'b0, 13, 14, "c_ptr14");
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 8; k++)
        drive(16'hFFFF, 1'b1, (14 + j) % 16, (14 + j) % 16, "c_all_rr");
    drive(16'h0000, 1'b0, 1, 2, "c_release");

    drive(16'b0000000100000000, 1'b1, 7, 2, "d_grant7");
    drive(16'b0000000100000000, 1'b1, 7, 2, "d_hold7a");
    drive(16'b0000000100000000, 1'b1, 7, 2, "d_hold7b");
    drive(16'h0000, 1'b0, 7, 8, "d_drop7");
    drive(16'h0000, 1'b0, 7, 8, "d_idle7");

    drive(16'b0000000001000000, 1'b1, 9, 8, "e_grant9");
    do_reset("e_async_reset");
    drive(16'b0000000001000000, 1'b1, 9, 0, "e_regrant9");
    drive(16'h0000, 1'b0, 9, 10, "e_release9");

    for (int n = 0; n < 10000; n++) begin
      r = req;
      for (int i = 0; i < 16; i++)
        if ($urandom_range(31) == 0) r[4'(i)] = ~r[4'(i)];
      req = r;
      @(posedge clk);
      #1;
    end
    req = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
